// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES cipher core.
//   AES_BLK_W   : block/state width in bits (128)
//   aes_state_e : FSM states of aes_cipher_core (IDLE, ROUND, DONE)
//   aes_nr()    : number of rounds for a key of nk 32-bit words
//   GF(2^8) helpers and the S-box / inverse S-box. The S-boxes are computed
//   algebraically (multiplicative inverse plus affine map), so no table is kept.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } aes_state_e;

    function automatic int aes_nr(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/aes_round_step.sv
// One AES round, purely combinational.
//   st   : current state, byte k at bits [8k:8k+7], byte k = row k%4, column k/4
//   rk   : round key for this round
//   last : final round, (Inv)MixColumns bypassed
//   inv  : inverse round (only honoured when AES_DECRYPT_EN is defined)
//   nxt  : next state
// Forward: AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk)
// Inverse (AES_DECRYPT_EN): InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk))
module aes_round_step
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] st,
    input  logic [0:AES_BLK_W-1] rk,
    input  logic                 last,
    input  logic                 inv,
    output logic [0:AES_BLK_W-1] nxt
);

    logic [0:AES_BLK_W-1] enc_nxt;

    always_comb begin
        logic [0:AES_BLK_W-1] sb;
        logic [0:AES_BLK_W-1] sr;
        logic [0:AES_BLK_W-1] mc;
        logic [7:0]           a [4];
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 4; i++) a[i] = 8'h00;
        for (int k = 0; k < 16; k++) sb[8*k +: 8] = sbox(st[8*k +: 8]);
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = sr[8*(r+4*c) +: 8];
            for (int r = 0; r < 4; r++)
                mc[8*(r+4*c) +: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                   ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        enc_nxt = (last ? sr : mc) ^ rk;
    end

`ifdef AES_DECRYPT_EN
    logic [0:AES_BLK_W-1] dec_nxt;

    always_comb begin
        logic [0:AES_BLK_W-1] isr;
        logic [0:AES_BLK_W-1] ark;
        logic [0:AES_BLK_W-1] imc;
        logic [7:0]           a [4];
        isr = '0;
        imc = '0;
        for (int i = 0; i < 4; i++) a[i] = 8'h00;
        // Row r rotates right by r columns; InvSubBytes folded into the same pass.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                isr[8*(r+4*c) +: 8] = inv_sbox(st[8*(r+4*((c+4-r)%4)) +: 8]);
        ark = isr ^ rk;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = ark[8*(r+4*c) +: 8];
            for (int r = 0; r < 4; r++)
                imc[8*(r+4*c) +: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b)
                                    ^ gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
        end
        dec_nxt = last ? ark : imc;
    end

    assign nxt = inv ? dec_nxt : enc_nxt;
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign nxt        = enc_nxt;
`endif

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 cipher core, one round per clock.
// Optional feature macro: AES_DECRYPT_EN (adds the decrypt port and inverse rounds).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake, in_block = plaintext (or ciphertext)
//   rk_idx / rk          : round-key index driven to an external combinational
//                          key store, rk returned in the same cycle
//   out_valid/out_ready  : output handshake, out_block = result
//   busy                 : core is in ROUND or DONE
//   decrypt              : (AES_DECRYPT_EN only) mode, sampled on accept
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid and out_block are held
// stable in DONE until out_ready is seen. in_valid outside IDLE is ignored.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:AES_BLK_W-1] in_block,
    output logic [3:0]           rk_idx,
    input  logic [0:AES_BLK_W-1] rk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:AES_BLK_W-1] out_block,
    output logic                 busy
`ifdef AES_DECRYPT_EN
    ,
    input  logic                 decrypt
`endif
);

    localparam int         NR  = aes_nr(NK);
    localparam logic [3:0] NR4 = 4'(NR);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_cipher_core: NK must be 4, 6 or 8");
    end

    aes_state_e           state;
    logic [0:AES_BLK_W-1] st;
    logic [3:0]           rnd;
    logic                 dec;
    logic                 start_dec;
    logic                 last;
    logic [0:AES_BLK_W-1] step_nxt;

    assign last = (rnd == NR4);

`ifdef AES_DECRYPT_EN
    assign start_dec = decrypt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 dec <= 1'b0;
        else if (state == S_IDLE && in_valid)    dec <= decrypt;
    end
`else
    assign start_dec = 1'b0;
    assign dec       = 1'b0;
`endif

    aes_round_step u_step (
        .st   (st),
        .rk   (rk),
        .last (last),
        .inv  (dec),
        .nxt  (step_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            st    <= '0;
            rnd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st    <= in_block ^ rk;
                        rnd   <= 4'd1;
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    st <= step_nxt;
                    // rnd parks at NR so it never exceeds the round count.
                    if (last) state <= S_DONE;
                    else      rnd   <= rnd + 4'd1;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rk_idx = 4'd0;
        case (state)
            S_IDLE:  rk_idx = start_dec ? NR4 : 4'd0;
            S_ROUND: rk_idx = dec ? (NR4 - rnd) : rnd;
            default: rk_idx = 4'd0;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_ROUND) || (state == S_DONE);
    assign out_block = (state == S_DONE) ? st : '0;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: three instances (NK = 4, 6, 8) share clock and
// reset; round keys come from a behavioural key expansion built from a
// table S-box. Known-answer vectors, back-pressure, mid-operation reset and
// a randomised stream against a byte-level reference cipher.
module tb_aes_cipher_core;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_block_a  [3];
    logic [3:0]   rk_idx_a    [3];
    logic [127:0] rk_a        [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_block_a [3];
    logic         busy_a      [3];
    logic         decrypt_a   [3];
    logic [127:0] rk_tab [3][16];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_cipher_core #(.NK(4 + 2*g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_block  (in_block_a[g]),
            .rk_idx    (rk_idx_a[g]),
            .rk        (rk_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_block (out_block_a[g]),
            .busy      (busy_a[g])
`ifdef AES_DECRYPT_EN
            ,
            .decrypt   (decrypt_a[g])
`endif
        );
        assign rk_a[g] = rk_tab[g][rk_idx_a[g]];
    end

    // ---------------- scoreboard state ----------------
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    // Key bytes are 00, 01, 02, ... as in the FIPS-197 example vectors.
    task automatic expand_keys(input int g);
        int           nk;
        int           nr;
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rcon;
        nk   = 4 + 2*g;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int g);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   tt;
        logic [127:0] res;
        int           nr;
        nr = 10 + 2*g;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_tab[g][0][127-8*k -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sb(s[k]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
                    tt = a[0] ^ a[1] ^ a[2] ^ a[3];
                    for (int i = 0; i < 4; i++) s[4*c+i] = a[i] ^ tt ^ xt(a[i] ^ a[(i+1)%4]);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_tab[g][r][127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // ---------------- driver tasks (called at posedge + #1) ----------------
    // Wait for out_valid, counting edges since accept; rk_idx is checked
    // against the expected round-key order on every ROUND cycle.
    task automatic wait_done(input int g, input bit dec, input int nr, output int lat, output bit idx_ok);
        int exp_idx;
        lat    = 0;
        idx_ok = 1'b1;
        while (!out_valid_a[g] && lat < 40) begin
            exp_idx = dec ? (nr - (lat + 1)) : (lat + 1);
            if (int'(rk_idx_a[g]) != exp_idx) idx_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_block(input int g, input bit dec, input logic [127:0] blk,
                             input logic [127:0] exp_out, input int nr, input string name);
        int lat;
        bit idx_ok;
        decrypt_a[g]   = dec;
        in_block_a[g]  = blk;
        in_valid_a[g]  = 1'b1;
        out_ready_a[g] = 1'b0;
        #1;
        check({name, " in_ready idle"}, 128'(in_ready_a[g]), 128'd1);
        check_int({name, " rk_idx idle"}, int'(rk_idx_a[g]), dec ? nr : 0);
        @(posedge clk); #1;
        in_valid_a[g] = 1'b0;
        decrypt_a[g]  = 1'b0;
        wait_done(g, dec, nr, lat, idx_ok);
        check_int({name, " latency"}, lat, nr);
        check_int({name, " rk_idx order"}, int'(idx_ok), 1);
        check({name, " out_block"}, out_block_a[g], exp_out);
        check({name, " rk_idx done"}, 128'(rk_idx_a[g]), 128'd0);
        out_ready_a[g] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[g] = 1'b0;
        check({name, " back to idle"}, 128'({out_valid_a[g], in_ready_a[g], busy_a[g]}), 128'b010);
    endtask

    // ---------------- known-answer table ----------------
    typedef struct {
        int           g;
        logic [127:0] pt;
        logic [127:0] ct;
        int           nr;
    } vec_t;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    vec_t vecs [3];

    initial begin
        int           lat;
        bit           ok;
        bit           stable_ok;
        bit           blocked_ok;
        logic [127:0] blk_b;
        logic [127:0] exp_b;

        vecs[0] = '{0, PT, CT4, 10};
        vecs[1] = '{1, PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12};
        vecs[2] = '{2, PT, 128'h8ea2b7ca516745bfeafc49904b496089, 14};

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid_a[g]  = 1'b0;
            in_block_a[g]  = '0;
            out_ready_a[g] = 1'b0;
            decrypt_a[g]   = 1'b0;
            expand_keys(g);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++)
            check($sformatf("reset outputs nk%0d", 4 + 2*g),
                  {in_ready_a[g], out_valid_a[g], busy_a[g], rk_idx_a[g], out_block_a[g]},
                  {1'b1, 1'b0, 1'b0, 4'd0, 128'h0});
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer vectors for each key length.
        for (int i = 0; i < 3; i++)
            run_block(vecs[i].g, 1'b0, vecs[i].pt, vecs[i].ct, vecs[i].nr,
                      $sformatf("kat nk%0d", 4 + 2*vecs[i].g));

`ifdef AES_DECRYPT_EN
        run_block(0, 1'b1, CT4, PT, 10, "decrypt nk4");
`endif

        // Back-pressure: hold DONE for 5 cycles with a second block offered.
        blk_b = 128'h3243f6a8885a308d313198a2e0370734;
        exp_b = ref_enc(blk_b, 0);
        in_block_a[0] = PT;
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        wait_done(0, 1'b0, 10, lat, ok);
        check_int("bp first latency", lat, 10);
        in_block_a[0] = blk_b;
        in_valid_a[0] = 1'b1;
        stable_ok  = 1'b1;
        blocked_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid_a[0] || out_block_a[0] !== CT4) stable_ok = 1'b0;
            if (in_ready_a[0] || !busy_a[0]) blocked_ok = 1'b0;
            @(posedge clk); #1;
        end
        check_int("bp output held", int'(stable_ok), 1);
        check_int("bp input blocked", int'(blocked_ok), 1);
        out_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[0] = 1'b0;
        check("bp idle after release", 128'({in_ready_a[0], out_valid_a[0]}), 128'b10);
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        wait_done(0, 1'b0, 10, lat, ok);
        check_int("bp second latency", lat, 10);
        check("bp second block", out_block_a[0], exp_b);
        out_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[0] = 1'b0;

        // Reset during round 5: block discarded, no output, next block clean.
        in_block_a[0] = blk_b;
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_int("pre-reset round busy", int'(busy_a[0]), 1);
        rst = 1'b1;
        #1;
        check("mid-op reset outputs",
              {in_ready_a[0], out_valid_a[0], busy_a[0], rk_idx_a[0], out_block_a[0]},
              {1'b1, 1'b0, 1'b0, 4'd0, 128'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        ok = 1'b1;
        repeat (14) begin
            if (out_valid_a[0] || busy_a[0]) ok = 1'b0;
            @(posedge clk); #1;
        end
        check_int("no output after abort", int'(ok), 1);
        run_block(0, 1'b0, PT, CT4, 10, "after reset");

        // Randomised stream with random in_valid gaps and out_ready.
        fork
            begin : driver
                bit acc;
                int bound;
                logic [127:0] pt;
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    exp_q.push_back(ref_enc(pt, 0));
                    in_block_a[0] = pt;
                    in_valid_a[0] = 1'b1;
                    bound = 0;
                    do begin
                        acc = in_ready_a[0];
                        @(posedge clk); #1;
                        bound++;
                    end while (!acc && bound < 200);
                    in_valid_a[0] = 1'b0;
                    if (!acc) check_int("stream accept timeout", 0, 1);
                end
            end
            begin : monitor
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < 100 && cyc < 20000) begin
                    out_ready_a[0] = 1'($urandom_range(0, 1));
                    if (out_valid_a[0] && out_ready_a[0]) begin
                        if (exp_q.size() == 0) check_int("stream unexpected output", 1, 0);
                        else check($sformatf("stream block %0d", got), out_block_a[0], exp_q.pop_front());
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready_a[0] = 1'b0;
                check_int("stream blocks received", got, 100);
            end
        join
        check_int("stream leftovers", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
